// File: rtl/riscv_decode_stage.sv
// RV32I decode stage between fetch and execute. Instructions enter through a
// valid/ready handshake and are decoded combinationally. The decoded control
// bundles queue in a small FIFO until execute takes them. The stage also
// tracks halt instructions (ECALL/EBREAK), supports a synchronous flush and
// counts retired decodes.
module riscv_decode_stage #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_func,
  output logic [2:0]       out_wdata_sel,
  output logic [2:0]       out_op2_immediate,
  output logic             out_op1_pc,
  output logic             out_op1_zero,
  output logic [2:0]       out_load_control,
  output logic [1:0]       out_store_control,
  output logic [2:0]       out_branch,
  output logic             out_illegal,
  output logic             program_done,
  output logic [CNT_W-1:0] instr_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  // Opcodes of the RV32I base set.
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // ALU function codes.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Register-file write source.
  localparam logic [2:0] WSEL_ALU = 3'd0;
  localparam logic [2:0] WSEL_MEM = 3'd1;
  localparam logic [2:0] WSEL_PC4 = 3'd2;

  // Operand-2 immediate format (REG = use rs2).
  localparam logic [2:0] OP2_REG = 3'd0;
  localparam logic [2:0] OP2_I   = 3'd1;
  localparam logic [2:0] OP2_S   = 3'd2;
  localparam logic [2:0] OP2_B   = 3'd3;
  localparam logic [2:0] OP2_U   = 3'd4;
  localparam logic [2:0] OP2_J   = 3'd5;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LW   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_func;
    logic [2:0]      wdata_sel;
    logic [2:0]      op2_immediate;
    logic            op1_pc;
    logic            op1_zero;
    logic [2:0]      load_control;
    logic [1:0]      store_control;
    logic [2:0]      branch;
    logic            illegal;
    logic            halt;
  } bundle_t;

  // Shared ALU selection for OP and OP-IMM; alt picks SUB/SRA.
  function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  // Pointers wrap at FIFO_DEPTH, which need not fill the pointer width.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    ptr_inc = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  bundle_t     dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign rd_f   = in_instr[11:7];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

  // Decode the presented instruction into a control bundle.
  // NOTE: every field gets a default before the case, so no path leaves a
  // combinational output unassigned and no latch is inferred.
  always_comb begin
    dec               = '0;
    dec.pc            = in_pc;
    dec.alu_func      = ALU_ADD;
    dec.wdata_sel     = WSEL_ALU;
    dec.op2_immediate = OP2_REG;
    dec.load_control  = LD_NONE;
    dec.store_control = ST_NONE;
    dec.branch        = BR_NONE;
    dec.halt          = (in_instr == INSTR_ECALL) || (in_instr == INSTR_EBREAK);
    imm32             = '0;
    case (opcode)
      OPC_OP: begin
        dec.rd       = rd_f;
        dec.rs1      = rs1_f;
        dec.rs2      = rs2_f;
        dec.alu_func = alu_op(funct3, in_instr[30]);
      end
      OPC_OP_IMM: begin
        dec.rd            = rd_f;
        dec.rs1           = rs1_f;
        dec.op2_immediate = OP2_I;
        imm32             = imm_i;
        dec.alu_func      = alu_op(funct3, (funct3 == 3'b101) && in_instr[30]);
      end
      OPC_LOAD: begin
        dec.rd            = rd_f;
        dec.rs1           = rs1_f;
        dec.op2_immediate = OP2_I;
        dec.wdata_sel     = WSEL_MEM;
        imm32             = imm_i;
        case (funct3)
          3'b000:  dec.load_control = LD_LB;
          3'b001:  dec.load_control = LD_LH;
          3'b010:  dec.load_control = LD_LW;
          3'b100:  dec.load_control = LD_LBU;
          3'b101:  dec.load_control = LD_LHU;
          default: dec.load_control = LD_NONE;
        endcase
      end
      OPC_STORE: begin
        dec.rs1           = rs1_f;
        dec.rs2           = rs2_f;
        dec.op2_immediate = OP2_S;
        imm32             = imm_s;
        case (funct3)
          3'b000:  dec.store_control = ST_SB;
          3'b001:  dec.store_control = ST_SH;
          3'b010:  dec.store_control = ST_SW;
          default: dec.store_control = ST_NONE;
        endcase
      end
      OPC_BRANCH: begin
        dec.rs1           = rs1_f;
        dec.rs2           = rs2_f;
        dec.op2_immediate = OP2_B;
        dec.op1_pc        = 1'b1;
        imm32             = imm_b;
        case (funct3)
          3'b000:  dec.branch = BR_BEQ;
          3'b001:  dec.branch = BR_BNE;
          3'b100:  dec.branch = BR_BLT;
          3'b101:  dec.branch = BR_BGE;
          3'b110:  dec.branch = BR_BLTU;
          3'b111:  dec.branch = BR_BGEU;
          default: dec.branch = BR_NONE;
        endcase
      end
      OPC_JAL: begin
        dec.rd            = rd_f;
        dec.op2_immediate = OP2_J;
        dec.op1_pc        = 1'b1;
        dec.wdata_sel     = WSEL_PC4;
        dec.branch        = BR_JUMP;
        imm32             = imm_j;
      end
      OPC_JALR: begin
        dec.rd            = rd_f;
        dec.rs1           = rs1_f;
        dec.op2_immediate = OP2_I;
        dec.wdata_sel     = WSEL_PC4;
        dec.branch        = BR_JUMP;
        imm32             = imm_i;
      end
      OPC_LUI: begin
        dec.rd            = rd_f;
        dec.op2_immediate = OP2_U;
        dec.op1_zero      = 1'b1;
        imm32             = imm_u;
      end
      OPC_AUIPC: begin
        dec.rd            = rd_f;
        dec.op2_immediate = OP2_U;
        dec.op1_pc        = 1'b1;
        imm32             = imm_u;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        // Legal, but no architectural effect at this stage beyond halt.
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  bundle_t              mem_q [FIFO_DEPTH];
  bundle_t              head;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     count_q, count_d;
  logic                 halt_pending_q, halt_pending_d;
  logic                 program_done_q, program_done_d;
  logic [CNT_W-1:0]     instr_count_q, instr_count_d;
  logic                 full, empty, push, pop;

  assign head     = mem_q[rd_ptr_q];
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign in_ready = !full && !halt_pending_q && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && out_ready && !flush;

  // Next-state for queue bookkeeping, halt latch, done flag and counter.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    halt_pending_d = halt_pending_q;
    program_done_d = program_done_q;
    instr_count_d  = instr_count_q;
    if (flush) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      halt_pending_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        if (dec.halt) halt_pending_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        if (head.halt) program_done_d = 1'b1;
        if (instr_count_q != '1) instr_count_d = instr_count_q + 1'b1;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  // Control state register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      halt_pending_q <= 1'b0;
      program_done_q <= 1'b0;
      instr_count_q  <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      halt_pending_q <= halt_pending_d;
      program_done_q <= program_done_d;
      instr_count_q  <= instr_count_d;
    end
  end

  // Bundle storage, written at the push edge.
  // NOTE: the storage array is deliberately not reset; resetting the
  // occupancy makes old entries unreachable and the outputs are gated by
  // out_valid, so stale contents are never visible.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  bundle_t out_b;

  // Present the head bundle, forcing every field to zero when empty.
  always_comb begin
    out_b = empty ? '0 : head;
  end

  assign out_valid         = !empty;
  assign out_pc            = out_b.pc;
  assign out_rs1           = out_b.rs1;
  assign out_rs2           = out_b.rs2;
  assign out_rd            = out_b.rd;
  assign out_imm           = out_b.imm;
  assign out_alu_func      = out_b.alu_func;
  assign out_wdata_sel     = out_b.wdata_sel;
  assign out_op2_immediate = out_b.op2_immediate;
  assign out_op1_pc        = out_b.op1_pc;
  assign out_op1_zero      = out_b.op1_zero;
  assign out_load_control  = out_b.load_control;
  assign out_store_control = out_b.store_control;
  assign out_branch        = out_b.branch;
  assign out_illegal       = out_b.illegal;
  assign program_done      = program_done_q;
  assign instr_count       = instr_count_q;

endmodule

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
Pipelined, parametrised successor to the combinational RV32I decoder. It accepts instructions through a valid/ready handshake and decodes them into the existing control bundle. It buffers decoded bundles in a FIFO_DEPTH-entry queue. Branch resolution moves out of the decoder (branch type is emitted, not pc_sel), and the block adds sign-extended immediates, illegal-opcode detection, flush, a halt latch and a retired-decode counter. It sits between fetch and execute.

Parameters:
XLEN, 32, datapath/PC/immediate width; legal values 32 or 64.
FIFO_DEPTH, 2, decoded-bundle queue entries; must be ≥1 and a power of two.
CNT_W, 16, width of instr_count.

Ports:
clock  in  1  system clock, rising edge
nReset  in  1  asynchronous active-low reset
in_valid  in  1  instruction presented
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
flush  in  1  synchronous queue flush
out_valid  out  1  head bundle valid
out_ready  in  1  execute accepts head
out_pc  out  XLEN  PC of bundle
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_imm  out  XLEN  sign-extended immediate
out_alu_func  out  4  ALU function, alu_codes.sv encoding
out_wdata_sel  out  3  register-file write select, existing encoding
out_op2_immediate  out  3  op2 immediate-type select, existing encoding
out_op1_pc, out_op1_zero  out  1 each  op1 source selects
out_load_control  out  3  existing load encoding
out_store_control  out  2  existing store encoding
out_branch  out  3  0=none, 1=BEQ, 2=BNE, 3=BLT, 4=BGE, 5=BLTU, 6=BGEU, 7=JAL/JALR
out_illegal  out  1  opcode outside RV32I
program_done  out  1  sticky halt indicator
instr_count  out  CNT_W  count of output handshakes

Behaviour:
- Reset (nReset low, async): queue empty, halt_pending=0, program_done=0, instr_count=0. All out_* = 0. in_ready is combinational and therefore reads 1.
- in_ready = !full && !halt_pending && !flush.
- Push when in_valid && in_ready. Decode is combinational from in_instr, and the bundle is written at the same edge.
- Latency: out_valid rises the cycle after the push at minimum. There is no same-cycle bypass.
- Pop when out_valid && out_ready. Push and pop in the same cycle are allowed whenever not full. Occupancy is unchanged in that case.
- FIFO order is strict. Read/write pointers wrap modulo FIFO_DEPTH, with a separate count for full/empty detection.
- All out_* fields are 0 when out_valid=0.
- Immediates: I/S/B/U/J formats, sign-extended to XLEN. The B/J LSB is 0. U-type places imm[31:12] and zero-fills the low bits. R-type gives 0.
- Illegal opcode: out_illegal=1. alu=ADD, load/store controls=0, wdata_sel=0, out_branch=0, rd=0.
- Halt (ECALL 0x00000073 or EBREAK 0x00100073):
  - On push, halt_pending←1 and the stage stops accepting.
  - On pop, program_done←1 at that edge. program_done stays set until reset.
- flush (synchronous, highest priority):
  - Empties the queue and clears halt_pending.
  - Any concurrent push is dropped.
  - Any concurrent pop does not count.
  - instr_count and program_done are unaffected.
- instr_count increments on each pop and saturates at all-ones.
- Reset asserted mid-operation discards all in-flight bundles immediately.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) at pc 0x100, out_ready=1 → next cycle out_valid=1, rd=3, rs1=1, rs2=2, alu=ADD, out_imm=0, out_branch=0; instr_count=1 after the pop edge.
- BEQ x1,x2,-4 (0xFE208EE3) → out_imm=0xFFFFFFFC (XLEN=32) / 0xFFFFFFFFFFFFFFFC (XLEN=64), out_branch=1.
- out_ready=0 with 3 instructions offered, FIFO_DEPTH=2 → in_ready=0 after 2 pushes; releasing out_ready yields the bundles in order and the 3rd is then accepted.
- 2 entries queued, flush=1 together with in_valid=1 → next cycle out_valid=0, pushed instruction lost, instr_count unchanged.
- EBREAK followed by ADD → in_ready=0 after EBREAK accepted, ADD never enters; program_done=1 the cycle after EBREAK is popped and stays 1 through a subsequent flush.
- 0x0000007F → out_illegal=1. Separately, nReset pulsed low with a full queue → out_valid=0, instr_count=0, in_ready=1 immediately.
